coherence_bus_ctrl: RTL and testbench

Two-core snooping bus controller sitting between the two L1 dcaches/icaches and the single-ported RAM. It is the responder side of the cache coherence/memory interface. It arbitrates dcache writebacks, dcache block fills and icache fetches, and drives snoops (`ccwait`/`ccinv`/`ccsnoopaddr`) into the non-requesting dcache. When the snooped cache asserts `cctrans`, it performs a cache-to-cache transfer with simultaneous RAM writeback.

---
 rtl/coherence_bus_ctrl.sv | 217 +++++++++++++++++++++
 tb/tb_coherence_bus_ctrl.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/coherence_bus_ctrl.sv
// Two-core snooping bus controller: arbitrates dcache writebacks, dcache
// block fills (with snoop and optional cache-to-cache transfer) and icache
// fetches onto a single-ported RAM.
module coherence_bus_ctrl #(
  parameter int         BLK_WORDS  = 2,
  parameter logic [1:0] RAM_FREE   = 2'd0,
  parameter logic [1:0] RAM_BUSY   = 2'd1,
  parameter logic [1:0] RAM_ACCESS = 2'd2,
  parameter logic [1:0] RAM_ERROR  = 2'd3
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic [1:0]       dREN,
  input  logic [1:0]       dWEN,
  input  logic [1:0][31:0] daddr,
  input  logic [1:0][31:0] dstore,
  input  logic [1:0]       ccwrite,
  input  logic [1:0]       cctrans,
  output logic [1:0]       dwait,
  output logic [1:0][31:0] dload,
  output logic [1:0]       ccwait,
  output logic [1:0]       ccinv,
  output logic [1:0][31:0] ccsnoopaddr,
  input  logic [1:0]       iREN,
  input  logic [1:0][31:0] iaddr,
  output logic [1:0]       iwait,
  output logic [1:0][31:0] iload,
  output logic             ramREN,
  output logic             ramWEN,
  output logic [31:0]      ramaddr,
  output logic [31:0]      ramstore,
  input  logic [31:0]      ramload,
  input  logic [1:0]       ramstate
);

  localparam int WORD_BITS = $clog2(BLK_WORDS);
  localparam int OFF_BITS  = WORD_BITS + 2;

  typedef enum logic [3:0] {
    IDLE, ARB, WB0, WB1, SNP_REQ, SNP_RESP, C2C0, C2C1, RD0, RD1, IFETCH
  } state_e;

  state_e state_q, state_d;
  logic   r_q, r_d;                   // requester of the current transaction
  logic   s_q, s_d;                   // snooped core (always !r)
  logic   xfer_inv_q, xfer_inv_d;     // requester asked for exclusive (BusRdX)
  logic   last_grant_q, last_grant_d;

  logic                 ram_access;
  logic                 gnt_valid;
  logic                 gnt_core;
  state_e               gnt_next;
  logic                 snoop_on;
  logic [WORD_BITS-1:0] word_idx;

  // Round-robin tie break: with both cores requesting, the one not granted last wins.
  function automatic logic pick(input logic [1:0] req, input logic last);
    return (req == 2'b11) ? ~last : req[1];
  endfunction

  // Decode RAM status: only ACCESS completes a word; FREE/BUSY/ERROR all stall.
  always_comb begin
    case (ramstate)
      RAM_ACCESS:                    ram_access = 1'b1;
      RAM_FREE, RAM_BUSY, RAM_ERROR: ram_access = 1'b0;
      default:                       ram_access = 1'b0;
    endcase
  end

  // Grant selection used in ARB: dWEN > dREN > iREN, round-robin within a class.
  always_comb begin
    gnt_valid = 1'b1;
    gnt_core  = 1'b0;
    gnt_next  = IDLE;
    if (|dWEN) begin
      gnt_core = pick(dWEN, last_grant_q);
      gnt_next = WB0;
    end else if (|dREN) begin
      gnt_core = pick(dREN, last_grant_q);
      gnt_next = SNP_REQ;
    end else if (|iREN) begin
      gnt_core = pick(iREN, last_grant_q);
      gnt_next = IFETCH;
    end else begin
      gnt_valid = 1'b0;
    end
  end

  // Next-state and output decode from state plus latched requester/snooped core.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves one unassigned, which would infer a latch.
    state_d      = state_q;
    r_d          = r_q;
    s_d          = s_q;
    xfer_inv_d   = xfer_inv_q;
    last_grant_d = last_grant_q;
    snoop_on     = 1'b0;
    word_idx     = '0;
    dwait        = 2'b11;
    iwait        = 2'b11;
    dload        = '0;
    iload        = '0;
    ccwait       = '0;
    ccinv        = '0;
    ccsnoopaddr  = '0;
    ramREN       = 1'b0;
    ramWEN       = 1'b0;
    ramaddr      = '0;
    ramstore     = '0;

    case (state_q)
      IDLE: begin
        if ((|dREN) || (|dWEN) || (|iREN)) state_d = ARB;
      end
      ARB: begin
        if (gnt_valid) begin
          r_d        = gnt_core;
          s_d        = ~gnt_core;
          xfer_inv_d = ccwrite[gnt_core];
        end
        state_d = gnt_next;
      end
      WB0, WB1: begin
        ramWEN   = 1'b1;
        ramaddr  = daddr[r_q];
        ramstore = dstore[r_q];
        if (ram_access) begin
          dwait[r_q] = 1'b0;
          if (state_q == WB0) begin
            state_d = WB1;
          end else begin
            state_d      = IDLE;
            last_grant_d = r_q;
          end
        end
      end
      SNP_REQ: begin
        snoop_on = 1'b1;
        state_d  = SNP_RESP;
      end
      SNP_RESP: begin
        snoop_on = 1'b1;
        state_d  = cctrans[s_q] ? C2C0 : RD0;
      end
      C2C0, C2C1: begin
        // The dirty block is forwarded to the requester and written back to RAM at once.
        snoop_on     = 1'b1;
        word_idx     = (state_q == C2C1) ? WORD_BITS'(1) : '0;
        ramWEN       = 1'b1;
        ramaddr      = {daddr[r_q][31:OFF_BITS], word_idx, 2'b00};
        ramstore     = dstore[s_q];
        dload[r_q]   = dstore[s_q];
        if (ram_access) begin
          dwait[r_q] = 1'b0;
          dwait[s_q] = 1'b0;
          if (state_q == C2C0) begin
            state_d = C2C1;
          end else begin
            snoop_on     = 1'b0;
            state_d      = IDLE;
            last_grant_d = r_q;
          end
        end
      end
      RD0, RD1: begin
        ramREN     = 1'b1;
        ramaddr    = daddr[r_q];
        dload[r_q] = ramload;
        if (ram_access) begin
          dwait[r_q] = 1'b0;
          if (state_q == RD0) begin
            state_d = RD1;
          end else begin
            state_d      = IDLE;
            last_grant_d = r_q;
          end
        end
      end
      IFETCH: begin
        ramREN     = 1'b1;
        ramaddr    = iaddr[r_q];
        iload[r_q] = ramload;
        if (ram_access) begin
          iwait[r_q]   = 1'b0;
          state_d      = IDLE;
          last_grant_d = r_q;
        end
      end
      default: state_d = IDLE;
    endcase

    if (snoop_on) begin
      ccwait[s_q]      = 1'b1;
      ccinv[s_q]       = xfer_inv_q;
      ccsnoopaddr[s_q] = daddr[r_q];
    end
  end

  // State and transaction-context registers; reset abandons any transaction in flight.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q      <= IDLE;
      r_q          <= 1'b0;
      s_q          <= 1'b1;
      xfer_inv_q   <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      state_q      <= state_d;
      r_q          <= r_d;
      s_q          <= s_d;
      xfer_inv_q   <= xfer_inv_d;
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: tb/tb_coherence_bus_ctrl.sv
// Self-checking bench for coherence_bus_ctrl: per-cycle vector table for the
// fill, cache-to-cache and stalled writeback flows, then hand-written
// sequences for arbitration, icache fetch and reset mid-transfer.
module tb_coherence_bus_ctrl;

  localparam logic [1:0] R_FREE = 2'd0;
  localparam logic [1:0] R_BUSY = 2'd1;
  localparam logic [1:0] R_ACC  = 2'd2;
  localparam logic [1:0] R_ERR  = 2'd3;

  logic             CLK = 1'b0;
  logic             nRST;
  logic [1:0]       dREN, dWEN, ccwrite, cctrans, iREN;
  logic [1:0][31:0] daddr, dstore, iaddr;
  logic [1:0]       dwait, ccwait, ccinv, iwait;
  logic [1:0][31:0] dload, ccsnoopaddr, iload;
  logic             ramREN, ramWEN;
  logic [31:0]      ramaddr, ramstore, ramload;
  logic [1:0]       ramstate;

  int total = 0;
  int bad   = 0;

  coherence_bus_ctrl dut (
    .CLK(CLK), .nRST(nRST),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .ccwrite(ccwrite), .cctrans(cctrans),
    .dwait(dwait), .dload(dload),
    .ccwait(ccwait), .ccinv(ccinv), .ccsnoopaddr(ccsnoopaddr),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate)
  );

  always #5 CLK = ~CLK;

  // Word-addressed RAM model: combinational read, write on an ACCESS cycle.
  logic [31:0] mem [0:1023];
  assign ramload = mem[ramaddr[11:2]];
  always @(posedge CLK) begin
    if (ramWEN && ramstate == R_ACC) mem[ramaddr[11:2]] <= ramstore;
  end

  function automatic logic [31:0] ram_init(input logic [31:0] addr);
    return 32'hC0DE_0000 | (addr >> 2);
  endfunction

  typedef struct {
    logic [1:0]  dren, dwen, ccwrite, cctrans, rs;
    logic [31:0] daddr0, daddr1, dstore0, dstore1;
    logic [1:0]  e_dwait, e_ccwait, e_ccinv;
    logic        e_ren, e_wen;
    logic [31:0] e_raddr, e_rstore, e_dload0, e_dload1, e_snp;
  } vec_t;

  function automatic vec_t base();
    vec_t v;
    v.dren = '0; v.dwen = '0; v.ccwrite = '0; v.cctrans = '0; v.rs = R_ACC;
    v.daddr0 = '0; v.daddr1 = '0; v.dstore0 = '0; v.dstore1 = '0;
    v.e_dwait = 2'b11; v.e_ccwait = '0; v.e_ccinv = '0;
    v.e_ren = 1'b0; v.e_wen = 1'b0;
    v.e_raddr = '0; v.e_rstore = '0; v.e_dload0 = '0; v.e_dload1 = '0; v.e_snp = '0;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    dREN = '0; dWEN = '0; ccwrite = '0; cctrans = '0; iREN = '0;
    daddr = '0; dstore = '0; iaddr = '0; ramstate = R_ACC;
  endtask

  task automatic check_idle(input string tag);
    check({tag, " dwait"},   32'(dwait), 32'h3);
    check({tag, " iwait"},   32'(iwait), 32'h3);
    check({tag, " cc"},      32'({ccwait, ccinv}), 32'h0);
    check({tag, " snpaddr"}, ccsnoopaddr[0] | ccsnoopaddr[1], 32'h0);
    check({tag, " loads"},   dload[0] | dload[1] | iload[0] | iload[1], 32'h0);
    check({tag, " ramctl"},  32'({ramREN, ramWEN}), 32'h0);
    check({tag, " ramaddr"}, ramaddr, 32'h0);
    check({tag, " ramstore"}, ramstore, 32'h0);
  endtask

  vec_t tbl[$];

  initial begin
    vec_t v;
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t v;
    for (int i = 0; i < 1024; i++) mem[i] = ram_init(32'(i) << 2);

    // ---- Single read miss, core 0, address 0x100, no dirty copy ----
    v = base(); v.dren = 2'b01; v.daddr0 = 32'h100;
    tbl.push_back(v);                                           // IDLE
    tbl.push_back(v);                                           // ARB
    v.e_ccwait = 2'b10; v.e_snp = 32'h100;
    tbl.push_back(v);                                           // SNP_REQ
    tbl.push_back(v);                                           // SNP_RESP
    v = base(); v.dren = 2'b01; v.daddr0 = 32'h100;
    v.e_ren = 1'b1; v.e_raddr = 32'h100; v.e_dwait = 2'b10; v.e_dload0 = ram_init(32'h100);
    tbl.push_back(v);                                           // RD0
    v.daddr0 = 32'h104; v.e_raddr = 32'h104; v.e_dload0 = ram_init(32'h104);
    tbl.push_back(v);                                           // RD1
    tbl.push_back(base());                                      // IDLE

    // ---- Cache-to-cache: core 1 BusRdX at 0x200, core 0 holds it dirty ----
    v = base(); v.dren = 2'b10; v.ccwrite = 2'b10; v.daddr1 = 32'h200;
    v.cctrans = 2'b01; v.dstore0 = 32'hAAAA;
    tbl.push_back(v);                                           // IDLE
    tbl.push_back(v);                                           // ARB
    v.e_ccwait = 2'b01; v.e_ccinv = 2'b01; v.e_snp = 32'h200;
    tbl.push_back(v);                                           // SNP_REQ
    tbl.push_back(v);                                           // SNP_RESP
    v.e_wen = 1'b1; v.e_raddr = 32'h200; v.e_rstore = 32'hAAAA;
    v.e_dload1 = 32'hAAAA; v.e_dwait = 2'b00;
    tbl.push_back(v);                                           // C2C0
    v.dstore0 = 32'hBBBB; v.e_ccwait = 2'b00; v.e_ccinv = 2'b00; v.e_snp = 32'h0;
    v.e_raddr = 32'h204; v.e_rstore = 32'hBBBB; v.e_dload1 = 32'hBBBB;
    tbl.push_back(v);                                           // C2C1, snoop drops
    tbl.push_back(base());                                      // IDLE

    // ---- Writeback core 0 with RAM stalls (BUSY/FREE/ERROR) ----
    v = base(); v.dwen = 2'b01; v.daddr0 = 32'h300; v.dstore0 = 32'h11;
    tbl.push_back(v);                                           // IDLE
    tbl.push_back(v);                                           // ARB
    v.e_wen = 1'b1; v.e_raddr = 32'h300; v.e_rstore = 32'h11;
    v.rs = R_BUSY; tbl.push_back(v);                            // WB0 stall
    v.rs = R_FREE; tbl.push_back(v);                            // WB0 stall
    v.rs = R_BUSY; tbl.push_back(v);                            // WB0 stall
    v.rs = R_ACC;  v.e_dwait = 2'b10; tbl.push_back(v);         // WB0 done
    v.daddr0 = 32'h304; v.dstore0 = 32'h22; v.e_raddr = 32'h304; v.e_rstore = 32'h22;
    v.e_dwait = 2'b11;
    v.rs = R_BUSY; tbl.push_back(v);                            // WB1 stall
    v.rs = R_ERR;  tbl.push_back(v);                            // WB1 stall
    v.rs = R_BUSY; tbl.push_back(v);                            // WB1 stall
    v.rs = R_ACC;  v.e_dwait = 2'b10; tbl.push_back(v);         // WB1 done
    tbl.push_back(base());                                      // IDLE

    // ---- Reset ----
    clear_inputs();
    nRST = 1'b0;
    #1;
    check_idle("reset");
    @(posedge CLK);
    @(negedge CLK);
    nRST = 1'b1;
    tick();

    // ---- Apply vector table ----
    for (int i = 0; i < tbl.size(); i++) begin
      dREN = tbl[i].dren; dWEN = tbl[i].dwen; ccwrite = tbl[i].ccwrite;
      cctrans = tbl[i].cctrans; ramstate = tbl[i].rs;
      daddr[0] = tbl[i].daddr0; daddr[1] = tbl[i].daddr1;
      dstore[0] = tbl[i].dstore0; dstore[1] = tbl[i].dstore1;
      @(negedge CLK);
      check($sformatf("row%0d dwait", i),    32'(dwait),  32'(tbl[i].e_dwait));
      check($sformatf("row%0d ccwait", i),   32'(ccwait), 32'(tbl[i].e_ccwait));
      check($sformatf("row%0d ccinv", i),    32'(ccinv),  32'(tbl[i].e_ccinv));
      check($sformatf("row%0d ramctl", i),   32'({ramREN, ramWEN}), 32'({tbl[i].e_ren, tbl[i].e_wen}));
      check($sformatf("row%0d ramaddr", i),  ramaddr,  tbl[i].e_raddr);
      check($sformatf("row%0d ramstore", i), ramstore, tbl[i].e_rstore);
      check($sformatf("row%0d dload0", i),   dload[0], tbl[i].e_dload0);
      check($sformatf("row%0d dload1", i),   dload[1], tbl[i].e_dload1);
      check($sformatf("row%0d snpaddr", i),  ccsnoopaddr[0] | ccsnoopaddr[1], tbl[i].e_snp);
      tick();
    end
    check("c2c mem 0x200", mem[32'h200 >> 2], 32'hAAAA);
    check("c2c mem 0x204", mem[32'h204 >> 2], 32'hBBBB);
    check("wb mem 0x300",  mem[32'h300 >> 2], 32'h11);
    check("wb mem 0x304",  mem[32'h304 >> 2], 32'h22);

    // ---- Arbitration: dWEN[1] beats dREN[0]; then dREN tie goes to core 0 ----
    clear_inputs();
    dWEN = 2'b10; daddr[1] = 32'h400; dstore[1] = 32'h55;
    dREN = 2'b01; daddr[0] = 32'h500;
    tick();                                                     // IDLE
    tick();                                                     // ARB
    @(negedge CLK);                                             // WB0
    check("arb wb first ramWEN", 32'(ramWEN), 32'h1);
    check("arb wb first ramaddr", ramaddr, 32'h400);
    check("arb wb first dwait", 32'(dwait), 32'h1);
    tick();
    daddr[1] = 32'h404; dstore[1] = 32'h66;
    @(negedge CLK);                                             // WB1
    check("arb wb1 dwait", 32'(dwait), 32'h1);
    tick();
    dWEN = 2'b00; dREN = 2'b11; daddr[1] = 32'h600;
    tick();                                                     // IDLE
    tick();                                                     // ARB
    @(negedge CLK);                                             // SNP_REQ for core 0
    check("arb rr ccwait", 32'(ccwait), 32'h2);
    check("arb rr snpaddr", ccsnoopaddr[1], 32'h500);
    check("arb snooped dwait", 32'(dwait), 32'h3);
    tick();                                                     // SNP_RESP
    tick();
    @(negedge CLK);                                             // RD0
    check("arb rd0 dwait", 32'(dwait), 32'h2);
    check("arb rd0 dload", dload[0], ram_init(32'h500));
    tick();
    daddr[0] = 32'h504;
    tick();                                                     // RD1
    dREN = 2'b10;
    tick();                                                     // IDLE
    tick();                                                     // ARB
    @(negedge CLK);                                             // SNP_REQ for core 1
    check("arb second ccwait", 32'(ccwait), 32'h1);
    check("arb second snpaddr", ccsnoopaddr[0], 32'h600);
    tick();                                                     // SNP_RESP
    tick();
    @(negedge CLK);                                             // RD0
    check("arb second rd0 dwait", 32'(dwait), 32'h1);
    check("arb second rd0 dload", dload[1], ram_init(32'h600));
    tick();
    daddr[1] = 32'h604;
    dREN = 2'b00;
    tick();                                                     // RD1
    check("arb mem 0x400", mem[32'h400 >> 2], 32'h55);
    check("arb mem 0x404", mem[32'h404 >> 2], 32'h66);

    // ---- icache fetch, core 0 ----
    clear_inputs();
    tick();
    iREN = 2'b01; iaddr[0] = 32'h40;
    tick();                                                     // IDLE
    tick();                                                     // ARB
    @(negedge CLK);                                             // IFETCH
    check("ifetch iwait", 32'(iwait), 32'h2);
    check("ifetch iload", iload[0], ram_init(32'h40));
    check("ifetch ramREN", 32'({ramREN, ramWEN}), 32'h2);
    check("ifetch ramaddr", ramaddr, 32'h40);
    tick();
    iREN = 2'b00;
    @(negedge CLK);
    check("ifetch after iwait", 32'(iwait), 32'h3);
    tick();

    // ---- Reset while stalled in C2C0 ----
    dREN = 2'b01; daddr[0] = 32'h700; cctrans = 2'b10; dstore[1] = 32'h77;
    tick();                                                     // IDLE
    tick();                                                     // ARB
    tick();                                                     // SNP_REQ
    ramstate = R_BUSY;
    tick();                                                     // SNP_RESP
    @(negedge CLK);                                             // C2C0 stalled
    check("c2c0 ramWEN", 32'(ramWEN), 32'h1);
    check("c2c0 ccwait", 32'(ccwait), 32'h2);
    check("c2c0 dload", dload[0], 32'h77);
    check("c2c0 stall dwait", 32'(dwait), 32'h3);
    tick();
    nRST = 1'b0;
    #1;
    check_idle("midrst");
    clear_inputs();
    @(negedge CLK);
    nRST = 1'b1;
    tick();
    check_idle("postrst");
    check("midrst mem 0x700", mem[32'h700 >> 2], ram_init(32'h700));
    // last_grant is back to 1, so core 0 must win this tie.
    dREN = 2'b11; daddr[0] = 32'h800; daddr[1] = 32'h900;
    tick();                                                     // IDLE
    tick();                                                     // ARB
    @(negedge CLK);                                             // SNP_REQ
    check("postrst grant ccwait", 32'(ccwait), 32'h2);
    check("postrst grant snpaddr", ccsnoopaddr[1], 32'h800);
    dREN = 2'b00;
    tick();                                                     // SNP_RESP
    tick();                                                     // RD0
    tick();                                                     // RD1
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
